// File: rtl/bcd_7seg_scan.sv
// rtl/bcd_7seg_scan.sv - captured BCD value driven onto a multiplexed 8-digit common-anode display
module bcd_7seg_scan #(
   parameter int DIV = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_bcd_in,
   input  logic        i_load,
   input  logic        i_blank_lz,
   output logic [6:0]  o_seg_n,
   output logic [7:0]  o_an_n,
   output logic        o_err
);

   localparam int            PW     = $clog2(DIV);
   localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

   logic [PW-1:0] r_p;
   logic [2:0]    r_d;
   logic [31:0]   r_shadow;
   logic          r_lz_en;
   logic          r_err;
   logic [6:0]    r_seg_n;
   logic [7:0]    r_an_n;

   logic [3:0]    w_nib;
   logic [31:0]   w_upper;
   logic          w_blank;
   logic [6:0]    w_seg_next;
   logic [7:0]    w_an_next;

   // Active-low hex glyphs; every non-decimal code shows "E".
   function automatic logic [6:0] f_decode(input logic [3:0] n);
      case (n)
         4'd0:    f_decode = 7'h40;
         4'd1:    f_decode = 7'h79;
         4'd2:    f_decode = 7'h24;
         4'd3:    f_decode = 7'h30;
         4'd4:    f_decode = 7'h19;
         4'd5:    f_decode = 7'h12;
         4'd6:    f_decode = 7'h02;
         4'd7:    f_decode = 7'h78;
         4'd8:    f_decode = 7'h00;
         4'd9:    f_decode = 7'h10;
         default: f_decode = 7'h06;
      endcase
   endfunction

   function automatic logic f_has_bad(input logic [31:0] v);
      f_has_bad = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (v[4*k +: 4] > 4'd9) f_has_bad = 1'b1;
      end
   endfunction

   // Prescaler counts cycles within a slot; its wrap advances the digit index.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_p <= '0;
         r_d <= 3'd0;
      end else if (r_p == P_LAST) begin
         r_p <= '0;
         r_d <= r_d + 3'd1;
      end else begin
         r_p <= r_p + 1'b1;
      end
   end

   // Capture the converter result together with its blanking mode and validity.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shadow <= 32'd0;
         r_lz_en  <= 1'b0;
         r_err    <= 1'b0;
      end else if (i_load) begin
         r_shadow <= i_bcd_in;
         r_lz_en  <= i_blank_lz;
         r_err    <= f_has_bad(i_bcd_in);
      end
   end

   // Digit d is a leading zero when it and everything above it is zero.
   always_comb begin
      w_nib      = r_shadow[{r_d, 2'b00} +: 4];
      w_upper    = r_shadow >> {r_d, 2'b00};
      w_blank    = r_lz_en && (r_d != 3'd0) && (w_upper == 32'd0);
      w_an_next  = 8'hFF;
      w_seg_next = 7'h7F;
      if ((r_p != '0) && !w_blank) begin
         w_an_next  = ~(8'd1 << r_d);
         w_seg_next = f_decode(w_nib);
      end
   end

   // Registered drivers keep the pads glitch-free; slot 0 of each digit stays dark.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_an_n  <= 8'hFF;
         r_seg_n <= 7'h7F;
      end else begin
         r_an_n  <= w_an_next;
         r_seg_n <= w_seg_next;
      end
   end

   assign o_seg_n = r_seg_n;
   assign o_an_n  = r_an_n;
   assign o_err   = r_err;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// tb/tb_bcd_7seg_scan.sv - self-checking bench for bcd_7seg_scan against a slot/frame model
module tb_bcd_7seg_scan;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] bcd_in = 32'd0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [6:0]  seg_n;
   logic [7:0]  an_n;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   // model state: edges since reset release, captured value, blanking, error
   int          m_cnt = 0;
   logic [31:0] m_shadow = 32'd0;
   logic        m_lz = 1'b0;
   logic        m_err = 1'b0;

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

   bcd_7seg_scan #(.DIV(DIV)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_bcd_in   (bcd_in),
      .i_load     (load),
      .i_blank_lz (blank_lz),
      .o_seg_n    (seg_n),
      .o_an_n     (an_n),
      .o_err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Display the cycle number cnt would produce, from position in the frame.
   function automatic void model_out(input int cnt, input logic [31:0] sh, input logic lz,
                                     output logic [6:0] seg, output logic [7:0] an);
      int p = cnt % DIV;
      int d = (cnt / DIV) % 8;
      logic [31:0] up = sh >> (4 * d);
      seg = 7'h7F;
      an  = 8'hFF;
      if (p != 0 && !(lz && d != 0 && up == 32'd0)) begin
         an  = ~(8'd1 << d);
         seg = glyph[up[3:0]];
      end
   endfunction

   function automatic logic bad_digit(input logic [31:0] v);
      bad_digit = 1'b0;
      for (int k = 0; k < 8; k++) if (((v >> (4 * k)) & 32'hF) > 9) bad_digit = 1'b1;
   endfunction

   task automatic tick(input logic ld, input logic [31:0] v, input logic lz);
      logic [6:0] es;
      logic [7:0] ea;
      load = ld; bcd_in = v; blank_lz = lz;
      model_out(m_cnt, m_shadow, m_lz, es, ea);
      @(posedge clk); #1;
      if (ld) begin
         m_shadow = v;
         m_lz = lz;
         m_err = bad_digit(v);
      end
      m_cnt++;
      chk("seg_n", {25'd0, seg_n}, {25'd0, es});
      chk("an_n", {24'd0, an_n}, {24'd0, ea});
      chk("err", {31'd0, err}, {31'd0, m_err});
      load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 32'hDEAD_BEEF, 1'b0);
   endtask

   task automatic align(input int pos);
      int guard = 0;
      while ((m_cnt % (8 * DIV)) != pos && guard < 64) begin
         idle(1);
         guard++;
      end
      chk("align", guard < 64, 1);
   endtask

   initial begin
      // reset held low
      repeat (2) @(posedge clk);
      #1;
      chk("rst_an", {24'd0, an_n}, 32'hFF);
      chk("rst_seg", {25'd0, seg_n}, 32'h7F);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;

      // first edge dead, second edge digit 0 showing 0
      idle(2);
      chk("first_lit_an", {24'd0, an_n}, 32'hFE);
      chk("first_lit_seg", {25'd0, seg_n}, 32'h40);
      idle(3);
      chk("dead_an", {24'd0, an_n}, 32'hFF);
      idle(1);
      chk("digit1_an", {24'd0, an_n}, 32'hFD);

      // leading-zero blanking on and off, all-zero value
      align(0);
      tick(1'b1, 32'h0000_1234, 1'b1);
      idle(8 * DIV + 2);
      tick(1'b1, 32'h0000_1234, 1'b0);
      idle(8 * DIV + 2);
      tick(1'b1, 32'h0000_0000, 1'b1);
      idle(8 * DIV + 2);

      // invalid digit then recovery
      tick(1'b1, 32'h0000_001A, 1'b0);
      chk("err_set", {31'd0, err}, 32'd1);
      idle(8 * DIV);
      tick(1'b1, 32'h0000_0099, 1'b0);
      chk("err_clear", {31'd0, err}, 32'd0);
      idle(8 * DIV);

      // load while digit 0 is mid-slot
      align(2);
      tick(1'b1, 32'h0000_0008, 1'b0);
      idle(1);
      chk("midslot_seg", {25'd0, seg_n}, 32'h00);
      idle(8 * DIV);

      // held load recaptures every cycle
      for (int i = 0; i < 6; i++) tick(1'b1, 32'h0000_0010 * i + 32'h3, 1'b1);

      // randomized loads mixed into the scan
      for (int i = 0; i < 400; i++) begin
         logic [31:0] v;
         v = $urandom;
         if ($urandom_range(0, 2) != 0) v = v & 32'h7777_7777;
         v = v >> (4 * $urandom_range(0, 8));
         tick($urandom_range(0, 3) == 0, v, 1'($urandom_range(0, 1)));
      end

      // reset mid-frame at digit 5
      tick(1'b1, 32'h1234_567A, 1'b0);
      align(5 * DIV + 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_an", {24'd0, an_n}, 32'hFF);
      chk("async_seg", {25'd0, seg_n}, 32'h7F);
      chk("async_err", {31'd0, err}, 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      m_cnt = 0; m_shadow = 32'd0; m_lz = 1'b0; m_err = 1'b0;
      idle(2);
      chk("restart_an", {24'd0, an_n}, 32'hFE);
      chk("restart_seg", {25'd0, seg_n}, 32'h40);
      idle(8 * DIV);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_7seg_scan.md
# bcd_7seg_scan

Downstream display stage for the binary-to-BCD converter: captures its 32-bit packed BCD result (8 nibbles, nibble 0 = least significant digit) and drives a time-multiplexed 8-digit common-anode seven-segment display. Contains a refresh prescaler, a digit-scan counter, a dead-time phase to suppress ghosting, optional leading-zero blanking, and a sticky invalid-digit flag.

## Interface
- DIV, 4, clock cycles per digit slot; legal range 2..65535.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bcd_in  in  32  packed BCD from the converter; nibble k = digit k.
- load  in  1  capture strobe; bcd_in is sampled on a rising clk edge with load=1.
- blank_lz  in  1  leading-zero blanking enable; sampled with load.
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}.
- an_n  out  8  active-low digit enables; bit k = digit k.
- err  out  1  sticky flag: last captured value held a nibble > 9.

## Operation
- Registers: shadow[31:0], lz_en, err, prescaler p (0..DIV-1), digit index d (0..7), and output registers seg_n and an_n.
- Capture: on an edge with load=1, shadow <= bcd_in and lz_en <= blank_lz. err <= 1 if any nibble of bcd_in is > 9, else 0. err changes only on load and on reset.
- Scan:
  - p increments every cycle and wraps DIV-1 -> 0.
  - On wrap, d increments and wraps 7 -> 0.
  - load never disturbs p or d.
- Leading zeros: digit k (k ≥ 1) is blanked when lz_en=1 and nibbles k..7 of shadow are all 0. Digit 0 is never blanked.
- Slot output: each output register is loaded from the current (p, d, shadow):
  - p=0 (dead time): an_n=8'hFF, seg_n=7'h7F.
  - p≥1, digit d blanked: an_n=8'hFF, seg_n=7'h7F.
  - p≥1, digit d not blanked: an_n = ~(1<<d); seg_n = decode(nibble d).
- Decode (active-low hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, any 10..15=06 ("E").

## Timing
- Reset (async, immediate):
  - p=0, d=0, shadow=0, lz_en=0.
  - err=0, an_n=8'hFF, seg_n=7'h7F.
- Output latency: outputs lag (p, d) by one cycle.
  - First edge after rst_n rises: registers p=0,d=0, so outputs stay dead (FF/7F).
  - Second edge: an_n=8'hFE, seg_n=7'h40.
- Slot and frame:
  - Each digit is lit for DIV-1 cycles, preceded by 1 dead cycle.
  - Full frame = 8*DIV cycles.
  - Digit order 0,1,…,7,0,…
- Load latency:
  - shadow, lz_en and err update on the load edge; err is visible immediately after it.
  - seg_n and an_n reflect the new shadow from the next edge onward, mid-slot included.
  - load held high recaptures every cycle.
- Back-to-back loads: the last one wins. No queuing.
- Reset mid-frame: all state returns to its reset values at once. The scan restarts at digit 0 after release.
- Reset has priority over load.

## Test plan
- Reset with DIV=4: rst_n low -> an_n=FF, seg_n=7F, err=0 while low. After release, an_n=FE and seg_n=40 appear on the 2nd edge. Then 3 lit cycles, then 1 dead cycle, then an_n=FD.
- Load 32'h0000_1234, blank_lz=1:
  - digit 0: an_n=FE, seg_n=19.
  - digit 1: an_n=FD, seg_n=30.
  - digit 2: an_n=FB, seg_n=24.
  - digit 3: an_n=F7, seg_n=79.
  - digits 4–7: an_n=FF, seg_n=7F.
  - The same load with blank_lz=0 shows 40 on digits 4–7.
- Load 32'h0000_0000, blank_lz=1 -> only digit 0 lit (seg_n=40). Every other slot reads FF/7F.
- Error flag:
  - Load 32'h0000_001A -> err=1 the cycle after the load edge; digit 0 shows seg_n=06, digit 1 shows 79.
  - Then load 32'h0000_0099 -> err=0, digit 0 shows 10.
- Load in mid-slot: assert load at p=2 of digit 0 with a new digit-0 value of 8 -> seg_n becomes 00 on the next edge. p and d continue without a skip; the frame length is still 32 cycles.
- Reset mid-frame: assert rst_n low at digit 5 -> outputs go FF/7F and err=0 asynchronously, and shadow clears. After release, scan restarts at digit 0 showing 40.
